// File: rtl/mips_ctr_pkg.sv
// Shared encodings for the multi-cycle MIPS controller:
// opcodes, FSM states, ALU/mux select codes and the control bundle.
package mips_ctr_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SE   = 2'b10;
  localparam logic [1:0] SRCB_SESH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_R)   || (op == OP_LW)  ||
           (op == OP_SW)  || (op == OP_BEQ) ||
           (op == OP_J)   || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_out_dec.sv
// Moore output decode: state (+ mem_ready in FETCH) to control bundle.
// Ports: state in, mem_ready in, ctl out (all unlisted fields are 0).
module multicycle_out_dec
  import mips_ctr_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctl_t   ctl
);

  always_comb begin
    ctl = '0;
    unique case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_source = PCS_ALU;
        // IR and PC+4 commit only when the fetch read lands
        ctl.ir_write  = mem_ready;
        ctl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_SESH;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_SE;
        ctl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.ior_d    = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.ior_d     = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_ADDIWB: begin
        ctl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_B;
        ctl.alu_op        = ALU_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCS_ALUOUT;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCS_JUMP;
      end
      default: ctl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctr.sv
// Multi-cycle MIPS main control FSM: state register, next state,
// retired-instruction counter; outputs decoded by multicycle_out_dec.
// Ports: clk, reset (async high), opCode, memReady in; datapath
// enables/selects, illegalOp, instrCount, state out.
module multicycle_ctr
  import mips_ctr_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opCode,
  input  logic             memReady,
  output logic             pcWrite,
  output logic             pcWriteCond,
  output logic             iorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             memToReg,
  output logic             regDst,
  output logic             regWrite,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic [1:0]       pcSource,
  output logic             illegalOp,
  output logic [CNT_W-1:0] instrCount,
  output logic [3:0]       state
);

  state_t           cur;
  state_t           nxt;
  logic             retire;
  logic [CNT_W-1:0] cnt;
  ctl_t             ctl;

  always_comb begin
    nxt    = cur;
    retire = 1'b0;
    unique case (cur)
      S_FETCH: if (memReady) nxt = S_DECODE;
      S_DECODE: begin
        unique case (opCode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_R:         nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDIEX;
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (memReady) nxt = S_MEMWB;
      S_MEMWR: begin
        if (memReady) begin
          nxt    = S_FETCH;
          retire = 1'b1;
        end
      end
      S_EXEC:   nxt = S_RWB;
      S_ADDIEX: nxt = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= S_FETCH;
      cnt <= '0;
    end else begin
      cur <= nxt;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  multicycle_out_dec u_dec (
    .state     (cur),
    .mem_ready (memReady),
    .ctl       (ctl)
  );

  // write strobes are held off for the whole reset window
  assign pcWrite     = ctl.pc_write  & ~reset;
  assign irWrite     = ctl.ir_write  & ~reset;
  assign regWrite    = ctl.reg_write & ~reset;
  assign memWrite    = ctl.mem_write & ~reset;
  assign pcWriteCond = ctl.pc_write_cond;
  assign iorD        = ctl.ior_d;
  assign memRead     = ctl.mem_read;
  assign memToReg    = ctl.mem_to_reg;
  assign regDst      = ctl.reg_dst;
  assign aluSrcA     = ctl.alu_src_a;
  assign aluSrcB     = ctl.alu_src_b;
  assign aluOp       = ctl.alu_op;
  assign pcSource    = ctl.pc_source;

  assign illegalOp  = (cur == S_DECODE) && !op_legal(opCode);
  assign instrCount = cnt;
  assign state      = cur;

endmodule

// File: tb/tb_multicycle_ctr.sv
// Scoreboard bench for multicycle_ctr: planned per-cycle expectations
// are queued by the driver and compared by a negedge monitor.
module tb_multicycle_ctr;

  localparam int CW = 4;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [5:0]    opCode = 6'd0;
  logic          memReady = 1'b0;
  logic          pcWrite, pcWriteCond, iorD, memRead, memWrite;
  logic          irWrite, memToReg, regDst, regWrite, aluSrcA;
  logic [1:0]    aluSrcB, aluOp, pcSource;
  logic          illegalOp;
  logic [CW-1:0] instrCount;
  logic [3:0]    state;

  multicycle_ctr #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opCode(opCode),
    .memReady(memReady), .pcWrite(pcWrite),
    .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite),
    .irWrite(irWrite), .memToReg(memToReg),
    .regDst(regDst), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .pcSource(pcSource),
    .illegalOp(illegalOp), .instrCount(instrCount),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]    st;
    logic          pw, pwc, iord, mr, mw, irw;
    logic          m2r, rd, rw, asa;
    logic [1:0]    asb, aop, pcs;
    logic          ill;
    logic [CW-1:0] cnt;
  } obs_t;

  obs_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  int   cnt = 0;

  function automatic bit legal(input logic [5:0] op);
    return op == LW || op == SW || op == RT ||
           op == BEQ || op == JMP || op == ADDI;
  endfunction

  // expected Moore outputs straight from the state table
  function automatic obs_t exp_of(input int st, input bit rdy,
                                  input logic [5:0] op, input int c);
    obs_t e;
    e = '0;
    e.st  = 4'(st);
    e.cnt = CW'(c);
    case (st)
      0: begin
        e.mr = 1; e.asb = 2'b01; e.irw = rdy; e.pw = rdy;
      end
      1: e.asb = 2'b11;
      2, 10: begin e.asa = 1; e.asb = 2'b10; end
      3: begin e.mr = 1; e.iord = 1; end
      4: begin e.rw = 1; e.m2r = 1; end
      5: begin e.mw = 1; e.iord = 1; end
      6: begin e.asa = 1; e.aop = 2'b10; end
      7: begin e.rw = 1; e.rd = 1; end
      8: begin
        e.asa = 1; e.aop = 2'b01; e.pwc = 1; e.pcs = 2'b01;
      end
      9: begin e.pw = 1; e.pcs = 2'b10; end
      11: e.rw = 1;
      default: ;
    endcase
    e.ill = (st == 1) && !legal(op);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t a;
    a.st = state; a.pw = pcWrite; a.pwc = pcWriteCond;
    a.iord = iorD; a.mr = memRead; a.mw = memWrite;
    a.irw = irWrite; a.m2r = memToReg; a.rd = regDst;
    a.rw = regWrite; a.asa = aluSrcA; a.asb = aluSrcB;
    a.aop = aluOp; a.pcs = pcSource; a.ill = illegalOp;
    a.cnt = instrCount;
    return a;
  endfunction

  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        a = sample();
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow got=%h required=none", a);
        end else begin
          e = q.pop_front();
          if (a !== e) begin
            failures++;
            $display("FAIL cycle st=%0d got=%h required=%h",
                     e.st, a, e);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  task automatic step(input int st, input bit rdy,
                      input logic [5:0] op);
    @(posedge clk);
    #1;
    opCode   = op;
    memReady = rdy;
    q.push_back(exp_of(st, rdy, op, cnt));
  endtask

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // plan one instruction's cycles from the opcode sequencing rules
  task automatic run_instr(input logic [5:0] op, input int wf,
                           input int wm);
    for (int i = 0; i < wf; i++) step(0, 0, junk());
    step(0, 1, junk());
    step(1, rb(), op);
    case (op)
      LW: begin
        step(2, rb(), op);
        for (int i = 0; i < wm; i++) step(3, 0, junk());
        step(3, 1, junk());
        step(4, rb(), junk());
      end
      SW: begin
        step(2, rb(), op);
        for (int i = 0; i < wm; i++) step(5, 0, junk());
        step(5, 1, junk());
      end
      RT: begin step(6, rb(), junk()); step(7, rb(), junk()); end
      BEQ: step(8, rb(), junk());
      JMP: step(9, rb(), junk());
      ADDI: begin
        step(10, rb(), junk()); step(11, rb(), junk());
      end
      default: ;
    endcase
    if (legal(op)) cnt = (cnt + 1) % (1 << CW);
  endtask

  task automatic drain();
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("sb_drain", q.size(), 0);
  endtask

  task automatic do_reset();
    memReady = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_cnt", instrCount, 0);
    chk("rst_ill", illegalOp, 0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    ops[0] = LW; ops[1] = SW; ops[2] = RT;
    ops[3] = BEQ; ops[4] = JMP; ops[5] = ADDI;

    do_reset();
    mon_en = 1'b1;
    run_instr(LW, 0, 0);
    run_instr(SW, 0, 3);
    run_instr(RT, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(JMP, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(LW, 2, 1);

    // reset asserted in the middle of an R-type EXEC cycle
    step(0, 1, junk());
    step(1, rb(), RT);
    step(6, 1, junk());
    drain();
    memReady = 1'b1;
    reset = 1'b1;
    #1;
    chk("arst_state", state, 0);
    chk("arst_rw", regWrite, 0);
    chk("arst_cnt", instrCount, 0);
    @(posedge clk);
    #1;
    chk("rsthold_state", state, 0);
    chk("rsthold_pw", pcWrite, 0);
    chk("rsthold_irw", irWrite, 0);
    chk("rsthold_rw", regWrite, 0);
    chk("rsthold_mr", memRead, 1);
    chk("rsthold_asb", aluSrcB, 2'b01);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rel_pw_rdy1", pcWrite, 1);
    chk("rel_irw_rdy1", irWrite, 1);
    memReady = 1'b0;
    #1;
    chk("rel_pw_rdy0", pcWrite, 0);
    cnt = 0;
    mon_en = 1'b1;

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 5)];
      run_instr(op, ($urandom_range(0, 3) == 0) ? 1 : 0,
                $urandom_range(0, 2));
    end
    drain();

    // counter wrap with a 4-bit count
    do_reset();
    mon_en = 1'b1;
    for (int n = 0; n < 17; n++) run_instr(ADDI, 0, 0);
    step(0, 0, junk());
    drain();
    chk("wrap_cnt", instrCount, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctr.md
# multicycle_ctr

Main control FSM for the multi-cycle MIPS datapath. It sequences one shared ALU, the instruction/data memory port and the register file across the cycles of each instruction, and drives `aluOp` into the ALU control decoder. The decoder resolves `aluOp`/`funct` to the ALU operation. The controller sits between the instruction register's opcode field and every datapath enable or mux select, and stalls on a memory-ready handshake.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- opCode  in  6  IR[31:26], valid from DECODE onward
- memReady  in  1  memory access completes this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load if ALU zero (beq)
- iorD  out  1  memory address: 0=PC, 1=ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- irWrite  out  1  instruction register load
- memToReg  out  1  register write data: 0=ALUOut, 1=MDR
- regDst  out  1  destination register: 0=rt, 1=rd
- regWrite  out  1  register file write
- aluSrcA  out  1  0=PC, 1=A
- aluSrcB  out  2  00=B, 01=4, 10=signext, 11=signext<<2
- aluOp  out  2  00=add, 01=sub, 10=use funct
- pcSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- illegalOp  out  1  one-cycle pulse on unknown opcode
- instrCount  out  CNT_W  retired instructions
- state  out  4  current state, for debug

## Operation
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Transitions:
  - FETCH→DECODE when memReady; otherwise hold.
  - DECODE→MEMADR (lw/sw), EXEC (R), BRANCH (beq), JUMP (j), ADDIEX (addi), or FETCH with illegalOp=1 (any other opcode).
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB when memReady; MEMWR→FETCH when memReady; otherwise hold.
  - EXEC→RWB; ADDIEX→ADDIWB.
  - MEMWB, RWB, ADDIWB, BRANCH, JUMP→FETCH.
- Moore outputs; any output not listed for a state is 0:
  - FETCH: memRead=1, aluSrcB=01, aluOp=00, pcSource=00; irWrite=pcWrite=memReady.
  - DECODE: aluSrcB=11, aluOp=00.
  - MEMADR, ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00.
  - MEMRD: memRead=1, iorD=1.
  - MEMWR: memWrite=1, iorD=1.
  - MEMWB: regWrite=1, memToReg=1.
  - EXEC: aluSrcA=1, aluOp=10.
  - RWB: regWrite=1, regDst=1.
  - ADDIWB: regWrite=1.
  - BRANCH: aluSrcA=1, aluOp=01, pcWriteCond=1, pcSource=01.
  - JUMP: pcWrite=1, pcSource=10.
- opCode is sampled only in DECODE and MEMADR; changes in other states are ignored.
- instrCount increments by 1 on every transition into FETCH from MEMWB, MEMWR, RWB, ADDIWB, BRANCH or JUMP. Illegal ops are not counted. The counter wraps to 0 after all-ones.

## Timing
- Reset (async assert, sync release): state=FETCH, instrCount=0, illegalOp=0.
- While reset is high, pcWrite, irWrite, regWrite and memWrite are forced 0. Other outputs show the FETCH decode.
- Reset mid-instruction abandons it with no write strobe and no count.
- Zero-wait CPI: R 4, lw 5, sw 4, beq 3, j 3, addi 4. Each memReady=0 cycle in FETCH, MEMRD or MEMWR adds 1.
- memReady is ignored in all other states.
- illegalOp is asserted in the DECODE cycle (combinational on state and opCode); the next state is FETCH.
- State and instrCount are registered; outputs are combinational from state (plus memReady in FETCH).

## Structure
- Package `mips_ctr_pkg`: opcode constants, state encodings, aluOp codes (ADD/SUB/FUNCT), aluSrcB and pcSource encodings. The ALU control decoder imports the aluOp codes from this package.
- Sub-module `multicycle_out_dec`: purely combinational decode of state and memReady to the control bundle. The top level holds the state register, next-state logic and counter.

## Test plan
- lw with memReady tied 1: states 0,1,2,3,4,0 → regWrite=memToReg=1 in cycle 5, instrCount 0→1.
- sw with memReady=0 for 3 cycles in MEMWR: memWrite=1 and iorD=1 held 4 cycles, total 7 cycles, no regWrite.
- R-type then beq then j back-to-back: cycles 4+3+3, aluOp 10 in EXEC, 01 in BRANCH, pcSource 10 in JUMP, instrCount=3.
- opCode=111111: illegalOp pulses 1 cycle in DECODE, return to FETCH, instrCount unchanged.
- Async reset asserted mid-EXEC: state=0 immediately; no regWrite while reset is high; after release, FETCH with pcWrite=irWrite=memReady.
- CNT_W=4, retire 17 addi: instrCount wraps and reads 1.
